// File: rtl/btb_predictor_pkg.sv
// -----------------------------------------------------------------------------
// btb_predictor_pkg
// Shared definitions for the branch target buffer and the control decode path:
//   - 2-bit bimodal counter encodings (strong/weak not-taken/taken)
//   - RV32I control-flow opcode constants
//   - helpers that derive the BTB index and tag widths from the geometry
// -----------------------------------------------------------------------------
package btb_predictor_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weak not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weak taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strong taken

    localparam logic [6:0] B_type    = 7'b1100011;
    localparam logic [6:0] JAL_type  = 7'b1101111;
    localparam logic [6:0] JALR_type = 7'b1100111;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    // Instructions are word aligned, so pc[1:0] is never part of the tag.
    function automatic int tag_width(input int pc_w, input int entries);
        return pc_w - 2 - $clog2(entries);
    endfunction

endpackage

// File: rtl/btb_predictor_sat_ctr2.sv
// -----------------------------------------------------------------------------
// sat_ctr2
// Next-state logic of a 2-bit saturating up/down counter.
// Ports:
//   ctr      in  2 : current counter value
//   up       in  1 : 1 = count towards strong-taken, 0 = towards strong-NT
//   ctr_next out 2 : next counter value, saturating at 00 and 11
// -----------------------------------------------------------------------------
module sat_ctr2
    import btb_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       up,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (up) begin
            if (ctr != CTR_ST)
                ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT)
                ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// -----------------------------------------------------------------------------
// btb_predictor
// Direct-mapped branch target buffer with 2-bit bimodal direction counters.
// Lookup (IF) is combinational; resolution (EX) computes the mispredict
// redirect combinationally and updates the table on the next CLK edge.
// Ports:
//   CLK, RSTn                 : clock, asynchronous active-low reset
//   IF_pc                     : fetch PC to look up
//   IF_hit/IF_pred_taken      : entry valid+tag match / predicted taken
//   IF_target/IF_next_pc      : stored target (0 on miss) / next fetch PC
//   EX_valid/EX_hold          : resolved instruction present / EX stalled
//   EX_is_branch/EX_is_jump   : conditional branch / JAL or JALR
//   EX_pc/EX_target/EX_taken  : resolved PC, target and outcome
//   EX_pred_taken/_target     : prediction carried down from IF
//   inv_all                   : invalidate every entry
//   redirect/redirect_pc      : mispredict flush and corrected PC
//   branch_cnt/mispred_cnt    : saturating performance counters
// -----------------------------------------------------------------------------
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter int         PC_W     = 12,
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter int         CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [PC_W-1:0]  IF_pc,
    output logic             IF_hit,
    output logic             IF_pred_taken,
    output logic [PC_W-1:0]  IF_target,
    output logic [PC_W-1:0]  IF_next_pc,
    input  logic             EX_valid,
    input  logic             EX_hold,
    input  logic             EX_is_branch,
    input  logic             EX_is_jump,
    input  logic [PC_W-1:0]  EX_pc,
    input  logic [PC_W-1:0]  EX_target,
    input  logic             EX_taken,
    input  logic             EX_pred_taken,
    input  logic [PC_W-1:0]  EX_pred_target,
    input  logic             inv_all,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = idx_width(ENTRIES);
    localparam int TAG_W = tag_width(PC_W, ENTRIES);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [PC_W-1:0]   target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    // ---------------- IF lookup ----------------
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;

    assign if_idx        = IF_pc[2 +: IDX_W];
    assign if_tag        = IF_pc[PC_W-1 : 2+IDX_W];
    assign IF_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign IF_pred_taken = IF_hit && ctr_q[if_idx][1];
    assign IF_target     = IF_hit ? target_q[if_idx] : '0;
    assign IF_next_pc    = IF_pred_taken ? IF_target : IF_pc + PC_W'(4);

    // ---------------- EX resolve ----------------
    logic             fire;
    logic             mispredict;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [1:0]       ctr_step;

    assign fire = EX_valid && !EX_hold && (EX_is_branch || EX_is_jump);

    // A correct direction with a stale target (e.g. JALR to a new address)
    // still has to flush.
    assign mispredict = fire &&
                        ((EX_taken != EX_pred_taken) ||
                         (EX_taken && EX_pred_taken && (EX_pred_target != EX_target)));

    assign redirect    = mispredict;
    assign redirect_pc = EX_taken ? EX_target : EX_pc + PC_W'(4);

    // The tag compare is redone here rather than trusting the IF result:
    // the entry may have been replaced while the instruction was in flight.
    assign ex_idx = EX_pc[2 +: IDX_W];
    assign ex_tag = EX_pc[PC_W-1 : 2+IDX_W];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    sat_ctr2 u_sat_ctr2 (
        .ctr      (ctr_q[ex_idx]),
        .up       (EX_taken),
        .ctr_next (ctr_step)
    );

    // ---------------- table update ----------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else if (inv_all) begin
            // Tags/targets are left as-is; a clear valid bit hides them.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else if (fire) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= EX_is_jump ? CTR_ST : ctr_step;
                if (EX_taken)
                    target_q[ex_idx] <= EX_target;
            end else if (EX_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= EX_target;
                ctr_q[ex_idx]    <= EX_is_jump ? CTR_ST : CTR_WT;
            end
        end
    end

    // ---------------- performance counters ----------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (fire && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispredict && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

    localparam int PC_W  = 12;
    localparam int CNT_W = 32;

    logic             CLK = 1'b0;
    logic             RSTn;
    logic [PC_W-1:0]  IF_pc;
    logic             IF_hit, IF_pred_taken;
    logic [PC_W-1:0]  IF_target, IF_next_pc;
    logic             EX_valid, EX_hold, EX_is_branch, EX_is_jump;
    logic [PC_W-1:0]  EX_pc, EX_target, EX_pred_target;
    logic             EX_taken, EX_pred_taken, inv_all;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;

    btb_predictor #(.ENTRIES(16), .PC_W(PC_W), .CTR_INIT(2'b01), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .IF_pc(IF_pc), .IF_hit(IF_hit), .IF_pred_taken(IF_pred_taken),
        .IF_target(IF_target), .IF_next_pc(IF_next_pc),
        .EX_valid(EX_valid), .EX_hold(EX_hold), .EX_is_branch(EX_is_branch),
        .EX_is_jump(EX_is_jump), .EX_pc(EX_pc), .EX_target(EX_target),
        .EX_taken(EX_taken), .EX_pred_taken(EX_pred_taken),
        .EX_pred_target(EX_pred_target), .inv_all(inv_all),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [PC_W-1:0] if_pc;
        logic            v, hold, br, jmp;
        logic [PC_W-1:0] ex_pc, tgt;
        logic            taken, ptaken;
        logic [PC_W-1:0] ptgt;
        logic            inv;
        logic            e_hit;
        logic [PC_W-1:0] e_next;
        logic            e_redir;
        logic [PC_W-1:0] e_rpc;
        int              e_b, e_m;
    } vec_t;

    typedef struct {
        logic [PC_W-1:0] if_pc;
        logic            hit;
        logic [PC_W-1:0] next;
        logic            redir;
        logic [PC_W-1:0] rpc;
        int              b, m;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(
        input logic [PC_W-1:0] if_pc, input logic v, hold, br, jmp,
        input logic [PC_W-1:0] ex_pc, tgt, input logic taken, ptaken,
        input logic [PC_W-1:0] ptgt, input logic inv,
        input logic e_hit, input logic [PC_W-1:0] e_next,
        input logic e_redir, input logic [PC_W-1:0] e_rpc, input int e_b, e_m);
        vec_t r;
        r.if_pc = if_pc; r.v = v; r.hold = hold; r.br = br; r.jmp = jmp;
        r.ex_pc = ex_pc; r.tgt = tgt; r.taken = taken; r.ptaken = ptaken;
        r.ptgt = ptgt; r.inv = inv; r.e_hit = e_hit; r.e_next = e_next;
        r.e_redir = e_redir; r.e_rpc = e_rpc; r.e_b = e_b; r.e_m = e_m;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        EX_valid = 0; EX_hold = 0; EX_is_branch = 0; EX_is_jump = 0;
        EX_pc = '0; EX_target = '0; EX_taken = 0; EX_pred_taken = 0;
        EX_pred_target = '0; inv_all = 0;
    endtask

    // One cycle: drive just after the edge, queue the expectation, compare
    // mid-cycle; the table update lands on the following edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t g;
        @(posedge CLK);
        #1;
        IF_pc = v.if_pc; EX_valid = v.v; EX_hold = v.hold; EX_is_branch = v.br;
        EX_is_jump = v.jmp; EX_pc = v.ex_pc; EX_target = v.tgt; EX_taken = v.taken;
        EX_pred_taken = v.ptaken; EX_pred_target = v.ptgt; inv_all = v.inv;
        e.if_pc = v.if_pc; e.hit = v.e_hit; e.next = v.e_next; e.redir = v.e_redir;
        e.rpc = v.e_rpc; e.b = v.e_b; e.m = v.e_m;
        sb.push_back(e);
        #3;
        g = sb.pop_front();
        chk({tag, " IF_hit"}, 32'(IF_hit), 32'(g.hit));
        chk({tag, " IF_next_pc"}, 32'(IF_next_pc), 32'(g.next));
        chk({tag, " IF_pred_taken"}, 32'(IF_pred_taken),
            32'(g.hit && (g.next != g.if_pc + PC_W'(4))));
        if (!g.hit) chk({tag, " IF_target"}, 32'(IF_target), 32'd0);
        chk({tag, " redirect"}, 32'(redirect), 32'(g.redir));
        if (g.redir) chk({tag, " redirect_pc"}, 32'(redirect_pc), 32'(g.rpc));
        chk({tag, " branch_cnt"}, branch_cnt, 32'(g.b));
        chk({tag, " mispred_cnt"}, mispred_cnt, 32'(g.m));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // if_pc v h br j ex_pc tgt tk ptk ptgt inv | hit next redir rpc b m
        tbl.push_back(mk('h040,0,0,0,0,'h000,'h000,0,0,'h000,0, 0,'h044,0,'h000, 0,0));
        tbl.push_back(mk('h040,1,0,1,0,'h040,'h100,1,0,'h000,0, 0,'h044,1,'h100, 0,0));
        tbl.push_back(mk('h040,1,0,1,0,'h040,'h100,1,1,'h100,0, 1,'h100,0,'h000, 1,1));
        tbl.push_back(mk('h040,1,0,1,0,'h040,'h100,1,1,'h100,0, 1,'h100,0,'h000, 2,1));
        tbl.push_back(mk('h040,1,0,1,0,'h040,'h100,0,1,'h100,0, 1,'h100,1,'h044, 3,1));
        tbl.push_back(mk('h040,1,0,1,0,'h040,'h100,0,1,'h100,0, 1,'h100,1,'h044, 4,2));
        tbl.push_back(mk('h040,0,0,0,0,'h000,'h000,0,0,'h000,0, 1,'h044,0,'h000, 5,3));
        tbl.push_back(mk('h440,1,0,0,1,'h440,'h200,1,0,'h000,0, 0,'h444,1,'h200, 5,3));
        tbl.push_back(mk('h040,0,0,0,0,'h000,'h000,0,0,'h000,0, 0,'h044,0,'h000, 6,4));
        tbl.push_back(mk('h440,0,0,0,0,'h000,'h000,0,0,'h000,0, 1,'h200,0,'h000, 6,4));
        tbl.push_back(mk('h440,1,0,0,1,'h440,'h204,1,1,'h200,0, 1,'h200,1,'h204, 6,4));
        tbl.push_back(mk('h440,1,0,0,0,'h440,'h300,1,0,'h000,0, 1,'h204,0,'h000, 7,5));
        tbl.push_back(mk('h104,1,0,1,0,'h104,'h300,0,0,'h000,0, 0,'h108,0,'h000, 7,5));
        tbl.push_back(mk('h442,0,0,0,0,'h000,'h000,0,0,'h000,0, 1,'h204,0,'h000, 8,5));
        tbl.push_back(mk('hFFC,1,0,1,0,'hFFC,'h100,0,1,'h100,0, 0,'h000,1,'h000, 8,5));
        tbl.push_back(mk('h104,0,0,0,0,'h000,'h000,0,0,'h000,0, 0,'h108,0,'h000, 9,6));

        IF_pc = '0;
        drive_idle();
        RSTn = 0;
        repeat (2) @(posedge CLK);
        #1 RSTn = 1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Stalled resolve: no update, redirect or count until released.
        for (int k = 0; k < 3; k++)
            apply(mk('h440,1,1,1,0,'h440,'h204,0,1,'h204,0, 1,'h204,0,'h000, 9,6),
                  $sformatf("hold%0d", k));
        apply(mk('h440,1,0,1,0,'h440,'h204,0,1,'h204,0, 1,'h204,1,'h444, 9,6), "release");
        // One step from 11 leaves 10, still predicting taken.
        apply(mk('h440,0,0,0,0,'h000,'h000,0,0,'h000,0, 1,'h204,0,'h000, 10,7), "post_hold");

        // Invalidate wins over a same-cycle allocate.
        apply(mk('h440,1,0,1,0,'h080,'h300,1,0,'h000,1, 1,'h204,1,'h300, 10,7), "inv_upd");
        apply(mk('h080,0,0,0,0,'h000,'h000,0,0,'h000,0, 0,'h084,0,'h000, 11,8), "inv_080");
        apply(mk('h440,0,0,0,0,'h000,'h000,0,0,'h000,0, 0,'h444,0,'h000, 11,8), "inv_440");

        // Re-allocate, then assert reset mid-cycle.
        apply(mk('h080,1,0,1,0,'h080,'h300,1,0,'h000,0, 0,'h084,1,'h300, 11,8), "realloc");
        apply(mk('h080,0,0,0,0,'h000,'h000,0,0,'h000,0, 1,'h300,0,'h000, 12,9), "pre_rst");
        #2 RSTn = 0;
        #1;
        chk("rst branch_cnt", branch_cnt, 32'd0);
        chk("rst mispred_cnt", mispred_cnt, 32'd0);
        chk("rst IF_hit", 32'(IF_hit), 32'd0);
        chk("rst IF_target", 32'(IF_target), 32'd0);
        chk("rst IF_next_pc", 32'(IF_next_pc), 32'h084);
        chk("rst redirect", 32'(redirect), 32'd0);
        @(posedge CLK);
        #1 RSTn = 1;
        apply(mk('h080,0,0,0,0,'h000,'h000,0,0,'h000,0, 0,'h084,0,'h000, 0,0), "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised branch target buffer with 2-bit bimodal direction counters, sitting between IF (lookup) and EX (resolve/update) of the 5-stage RV32I pipeline. It is the next generation of the control unit's prediction path: lookup, update and mispredict redirect live in one block instead of being scattered across control decode. It adds configurable depth and PC width, hysteresis counters, JAL/JALR target caching, bulk invalidate and saturating performance counters.

## Interface
- `ENTRIES`, 16, number of direct-mapped entries; power of two, ≥2; `IDX_W = log2(ENTRIES)`.
- `PC_W`, 12, byte-address PC width; `TAG_W = PC_W - 2 - IDX_W`, must be ≥1.
- `CTR_INIT`, 2'b01, counter value after reset and invalidate.
- `CNT_W`, 32, performance counter width.
- `CLK` in 1: single clock, rising edge.
- `RSTn` in 1: asynchronous, active-low reset.
- `IF_pc` in PC_W: fetch PC.
- `IF_hit` out 1: the indexed entry is valid and its tag matches.
- `IF_pred_taken` out 1: `IF_hit & ctr[1]`.
- `IF_target` out PC_W: stored target; 0 when `IF_hit=0`.
- `IF_next_pc` out PC_W: `IF_pred_taken ? IF_target : IF_pc+4`.
- `EX_valid` in 1: EX holds a resolved control-flow instruction.
- `EX_hold` in 1: EX is stalled this cycle; blocks update, redirect and counting.
- `EX_is_branch` in 1: conditional branch (B-type).
- `EX_is_jump` in 1: JAL or JALR.
- `EX_pc`, `EX_target` in PC_W: instruction PC and computed target.
- `EX_taken` in 1: actual outcome (1 for jumps).
- `EX_pred_taken` in 1, `EX_pred_target` in PC_W: IF prediction carried down the pipe.
- `inv_all` in 1: synchronous invalidate of all entries.
- `redirect` out 1, `redirect_pc` out PC_W: mispredict flush and correct PC.
- `branch_cnt`, `mispred_cnt` out CNT_W: performance counters.

## Operation
- Index is `pc[2 +: IDX_W]`. Tag is `pc[PC_W-1 : 2+IDX_W]`. `pc[1:0]` is ignored.
- `fire = EX_valid & ~EX_hold & (EX_is_branch | EX_is_jump)`.
- Mispredict: `fire` and either `EX_taken != EX_pred_taken`, or both are taken and `EX_pred_target != EX_target`.
- `redirect = mispredict`. `redirect_pc = EX_taken ? EX_target : EX_pc+4`, computed mod 2^PC_W.
- Update on `fire`; tag compare is redone at `EX_pc`.
  - Hit: counter increments on taken and decrements on not-taken, saturating at 00/11. On taken, target is overwritten with `EX_target`. For jumps, counter is forced to 11.
  - Miss and taken: allocate the entry (valid=1, tag, target). Counter is 10 for branches, 11 for jumps. Any aliased entry is replaced.
  - Miss and not-taken: no change.
- `inv_all`: all valid bits = 0, all counters = `CTR_INIT`. Beats a same-cycle update.
- `branch_cnt` increments on `fire`. `mispred_cnt` increments on mispredict. Both saturate at all-ones.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

## Timing
- Lookup is combinational from `IF_pc` to all `IF_*` outputs (0-cycle latency).
- Redirect is combinational from EX inputs, in the same cycle as resolution.
- Updates are registered on the `CLK` edge and visible to lookup the next cycle.
  - Same-cycle lookup and update to the same index returns the old contents (no bypass).
- Reset (async, any time, including mid-update): valid = 0, counters = `CTR_INIT`, targets/tags = 0, `branch_cnt`/`mispred_cnt` = 0. Outputs then read `IF_hit=0`, `IF_pred_taken=0`, `IF_target=0`, `IF_next_pc=IF_pc+4`, `redirect=0`.
- `EX_hold=1` over N cycles yields exactly one update, on the first unheld cycle.

## Structure
- Shared package holds:
  - counter encoding constants (`CTR_SNT/WNT/WT/ST`);
  - opcode constants (`B_type`, `JAL_type`, `JALR_type`) reused by decode;
  - index/tag width function.
- One sub-module, `sat_ctr2`: 2-bit saturating up/down next-state logic, instantiated once on the update path.
- Storage is flop arrays (valid, tag, target, ctr); no SRAM macro.

## Test plan
- Reset, then `IF_pc=0x040` → `IF_hit=0`, `IF_next_pc=0x044`, both perf counters 0.
- Cold taken branch, `EX_pc=0x040`, target `0x100`, `EX_pred_taken=0` → `redirect=1`, `redirect_pc=0x100`. Next cycle, `IF_pc=0x040` → `IF_hit=1`, `IF_next_pc=0x100`; `branch_cnt=1`, `mispred_cnt=1`.
- Hysteresis: train `0x040` taken ×3 (ctr=11). Then not-taken → `redirect_pc=0x044`, still predicts taken (10). Second not-taken → ctr 01, `IF_next_pc=0x044`.
- Aliasing at 16 entries: entry `0x040` live; lookup `0x440` → `IF_hit=0`. JAL at `0x440`, target `0x200` → entry replaced, ctr=11; lookup `0x040` → miss.
- `EX_valid=1`, `EX_hold=1` for 3 cycles, then released → single counter step, `branch_cnt +1`, `redirect` only in the released cycle.
- `inv_all` in the same cycle as a taken update to `0x080` → every subsequent lookup misses. Asserting `RSTn=0` mid-stream zeros both perf counters immediately, without a clock edge.
